// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
//
// Computes a WORDS x 32-bit sum or difference by stepping one shared 32-bit
// adder over the operands, least-significant word first. The carry between
// words is held in a register.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            command strobe, accepted in IDLE or DONE
//   op_sub           0 = a+b, 1 = a-b (captured with start)
//   a_in, b_in       W-bit operands (captured with start)
//   abort            cancels the operation in flight (RUN only)
//   busy             high while an operation is in progress
//   done             one-cycle pulse; result/cout/overflow are valid
//   result           W-bit sum or difference
//   cout             final carry out (subtract: 1 = no borrow)
//   overflow         two's-complement signed overflow of the W-bit result
//
// Also contains wallace_adder, the 32-bit carry-lookahead adder the sequencer
// drives.

module wallace_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;

    // Eight 4-bit lookahead groups. Inside a group every carry comes straight
    // from the group's carry-in. Only the group carries ripple between groups.
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int j = 0; j < 8; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            if (j < 7) begin
                c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                         | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            end
        end
        sum = p ^ c;
    end

endmodule

module mp_add_seq #(
    parameter int WORDS = 4,
    parameter int IDXW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [32*WORDS-1:0]   a_in,
    input  logic [32*WORDS-1:0]   b_in,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  overflow
);

    localparam int W = 32 * WORDS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            op_reg;
    logic [IDXW-1:0] k;
    logic            carry;

    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic            add_cin;
    logic [31:0]     add_sum;
    logic            word_cout;
    logic            word_ovf;
    logic            last_word;
    logic            accept;

    wallace_adder u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // The adder inputs are held at zero outside RUN. For subtract, B is
    // inverted and the +1 enters through the carry, which is seeded with
    // op_sub at start.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_a   = a_reg[32*k +: 32];
            add_b   = b_reg[32*k +: 32] ^ {32{op_reg}};
            add_cin = carry;
        end
    end

    // The adder has no carry-out port. Recover the carry from the top bits:
    // a carry leaves bit 31 when both inputs are set, or when exactly one is
    // set and the sum bit is clear.
    assign word_cout = (add_a[31] & add_b[31])
                     | ((add_a[31] ^ add_b[31]) & ~add_sum[31]);
    assign word_ovf  = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

    assign last_word = (k == IDXW'(WORDS - 1));
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Sequencer. The result is written in place one word per cycle. On the
    // last word the final flags are latched and the index parks at zero, so
    // it never passes WORDS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= 1'b0;
            k        <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_reg  <= a_in;
                        b_reg  <= b_in;
                        op_reg <= op_sub;
                        k      <= '0;
                        carry  <= op_sub;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        k     <= '0;
                    end else begin
                        result[32*k +: 32] <= add_sum;
                        carry              <= word_cout;
                        if (last_word) begin
                            cout     <= word_cout;
                            overflow <= word_ovf;
                            k        <= '0;
                            state    <= S_DONE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: self-checking bench for mp_add_seq with WORDS=4 (128-bit).
// Runs a table of directed vectors and randomized operations. The randomized
// operations are compared against a plain 129-bit arithmetic model. The bench
// also covers the control hazards and the asynchronous reset.

module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    mp_add_seq #(.WORDS(WORDS), .IDXW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a_in     (a_in),
        .b_in     (b_in),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: plain wide arithmetic on the whole operands.
    function automatic logic [W+1:0] model(input logic op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0] full;
        logic       ov;
        if (op) begin
            full = {1'b0, a} + {1'b0, ~b} + 1;
            ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic check_val(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one command. Call at a negedge. Returns at the negedge where done
    // is seen, or when the cycle bound runs out. edges counts the clock edges
    // from the start edge to done. busy_ok is cleared if busy was low while
    // the operation was in progress.
    task automatic apply_stimulus(input logic op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output int edges,
                                  output logic busy_ok);
        start  = 1'b1;
        op_sub = op;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        edges   = 0;
        busy_ok = 1'b1;
        while (!done && edges < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic check_output(input string name, input logic [W-1:0] res,
                                input logic co, input logic ov);
        check_val({name, "_done"}, W'(done), W'(1'b1));
        check_val({name, "_res"}, result, res);
        check_val({name, "_cout"}, W'(cout), W'(co));
        check_val({name, "_ovf"}, W'(overflow), W'(ov));
    endtask

    vec_t         vecs[$];
    int           edges;
    int           edges2;
    int           n_done;
    logic         busy_ok;
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;

    initial begin
        vecs.push_back('{"ripple",   1'b0, {W{1'b1}}, W'(1), W'(0), 1'b1, 1'b0});
        vecs.push_back('{"borrow",   1'b1, W'(0), W'(1), {W{1'b1}}, 1'b0, 1'b0});
        vecs.push_back('{"sub_eq",   1'b1, W'(5), W'(5), W'(0), 1'b1, 1'b0});
        vecs.push_back('{"sovf_add", 1'b0, {1'b0, {(W-1){1'b1}}}, W'(1),
                         {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1});
        vecs.push_back('{"sovf_sub", 1'b1, {1'b1, {(W-1){1'b0}}}, W'(1),
                         {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1});
        vecs.push_back('{"word_cy",  1'b0, W'(64'hFFFF_FFFF), W'(1),
                         W'(64'h1_0000_0000), 1'b0, 1'b0});

        // Reset state
        #2;
        check_val("rst_busy", W'(busy), '0);
        check_val("rst_done", W'(done), '0);
        check_val("rst_res", result, '0);
        check_val("rst_flags", W'({cout, overflow}), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, edges, busy_ok);
            check_val({vecs[i].name, "_lat"}, W'(edges), W'(4));
            check_val({vecs[i].name, "_busy"}, W'(busy_ok), W'(1'b1));
            check_output(vecs[i].name, vecs[i].res, vecs[i].co, vecs[i].ov);
            @(negedge clk);
            check_val({vecs[i].name, "_pulse"}, W'(done), '0);
            check_val({vecs[i].name, "_hold"}, result, vecs[i].res);
        end

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            for (int w = 0; w < WORDS; w++) begin
                ra[32*w +: 32] = $urandom;
                rb[32*w +: 32] = $urandom;
            end
            if (i % 4 == 1) ra[63:0] = {64{1'b1}};
            if (i % 4 == 2) rb[W-1 -: 32] = ra[W-1 -: 32];
            rop = 1'($urandom_range(0, 1));
            m = model(rop, ra, rb);
            apply_stimulus(rop, ra, rb, edges, busy_ok);
            check_val("rand_lat", W'(edges), W'(4));
            check_output("rand", m[W-1:0], m[W], m[W+1]);
            @(negedge clk);
        end

        // A second start during RUN is ignored
        m = model(1'b0, W'(128'h1234), W'(128'h1111));
        start = 1'b1; op_sub = 1'b0; a_in = W'(128'h1234); b_in = W'(128'h1111);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_sub = 1'b1; a_in = W'(128'h9999); b_in = W'(128'h7);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 2;
        while (!done && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_val("ign_lat", W'(edges), W'(4));
        check_output("ign", m[W-1:0], m[W], m[W+1]);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("ign_extra_done", W'(n_done), '0);

        // Back-to-back: the second start is issued in the DONE cycle
        apply_stimulus(1'b0, W'(100), W'(23), edges, busy_ok);
        check_output("b2b1", W'(123), 1'b0, 1'b0);
        apply_stimulus(1'b1, W'(100), W'(23), edges2, busy_ok);
        check_val("b2b_gap", W'(edges2 + 1), W'(5));
        check_output("b2b2", W'(77), 1'b1, 1'b0);
        @(negedge clk);

        // Abort in RUN cycle 1
        start = 1'b1; op_sub = 1'b0; a_in = W'(5); b_in = W'(6);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", W'(busy), '0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) n_done++;
            @(negedge clk);
        end
        check_val("abort_quiet", W'(n_done), '0);

        // Asynchronous reset mid-RUN, between clock edges
        start = 1'b1; op_sub = 1'b0; a_in = {W{1'b1}}; b_in = {W{1'b1}};
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", W'(busy), '0);
        check_val("arst_done", W'(done), '0);
        check_val("arst_res", result, '0);
        check_val("arst_flags", W'({cout, overflow}), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b0, W'(3), W'(4), edges, busy_ok);
        check_val("post_rst_lat", W'(edges), W'(4));
        check_output("post_rst", W'(7), 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared 32-bit carry-lookahead adder instance (`wallace_adder`: a, b, cin -> sum).
- Performs a WORDS×32-bit add or subtract by iterating the adder over one 32-bit word per cycle, least-significant word first, with a registered inter-word carry.
- Sits between a start/done command interface and the adder; it is the only driver of the adder's inputs.

Parameters:
- WORDS, 4, number of 32-bit words per operand (operand width W = 32*WORDS); legal range 2..16.
- IDXW, 4, width of the word-index counter; must satisfy 2^IDXW >= WORDS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  command strobe; sampled only while idle.
- op_sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a_in  input  W  operand A, captured with start.
- b_in  input  W  operand B, captured with start.
- abort  input  1  synchronous cancel of the operation in flight.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result, cout and overflow are valid.
- result  output  W  sum/difference.
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow of the W-bit result.

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; index, carry and operand registers cleared.
- States:
  - IDLE: start=1 at edge T0 captures a_in, b_in and op_sub; sets index k=0 and carry=op_sub; goes to RUN. busy=1 from T0.
  - RUN: in each cycle the adder is driven with a = A word k, b = (B word k) XOR {32{op_sub}}, cin = carry.
    - At the next edge: result word k <= sum; carry <= word carry-out; k <= k+1.
    - Word carry-out = (a31 & b31) | ((a31 ^ b31) & ~sum31), using the adder-input b.
  - Last word: at the edge that writes word WORDS-1, latch cout = final carry and overflow = (a31 == b31) && (sum31 != a31) on the top word, adder-input b. Go to DONE.
  - DONE: lasts one cycle; done=1, busy=0. Returns to IDLE next edge.
    - start is also honoured in DONE (back-to-back), so that next edge enters RUN directly.
- Latency: done is high in the cycle following edge T0+WORDS. Throughput is one operation per WORDS+1 cycles.
- Output stability:
  - result is written in place word by word and is not valid while busy=1.
  - result, cout and overflow hold their values after done until the next accepted start.
- start while busy=1 (RUN) is ignored, with no queuing.
- abort=1 in RUN: return to IDLE at the next edge. done is not pulsed. busy=0. result/cout/overflow keep their partial contents and are invalid. abort in IDLE or DONE has no effect.
- abort and start both high in DONE: abort has no effect and start is accepted.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Index wrap: k never exceeds WORDS-1; the RUN→DONE transition is decoded on k==WORDS-1.
- Adder use: the adder instance is combinational, so nothing is pipelined inside it. Its inputs are held at 0 in IDLE and DONE.

Test Plan (WORDS=4, W=128):
- Full carry ripple: add, a=all ones, b=1 -> result=0, cout=1, overflow=0; done exactly 4 cycles after the start edge, busy high for cycles 1..4.
- Borrow: sub, a=0, b=1 -> result=all ones (0xFFFF…FFFF), cout=0, overflow=0. Then sub, a=5, b=5 -> result=0, cout=1.
- Signed overflow: add, a=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1 -> result=0x80000000_00000000_00000000_00000000, overflow=1, cout=0. Also sub, a=0x8000…0, b=1 -> result=0x7FFF…F, overflow=1.
- Inter-word carry: add, a=0x00000000_00000000_00000000_FFFFFFFF, b=0x1 -> result=0x00000000_00000000_00000001_00000000, cout=0.
- Control hazards:
  - start pulsed again in RUN cycle 2 -> ignored; a single done with the first operation's result.
  - Back-to-back: new start in the DONE cycle -> second done arrives 5 cycles after the first.
  - abort in RUN cycle 1 -> no done; busy=0 next cycle.
- Async reset: assert rst mid-RUN between clock edges -> busy, done, result, cout and overflow are 0 immediately. After release, a new add 3+4 yields result=7 with done on schedule.
